uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 145 ++++++++++++++
 tb/tb_uart_tx_framer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Serialises one DATA_WIDTH payload per handshake into a UART frame:
//   one start bit (0), the data bits LSB first, an optional even-parity bit,
//   and one stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     - undefined (default): frame = start + data + stop.
//     - defined: an even-parity bit (XOR of the payload) is inserted between
//       the data MSB and the stop bit.
//
// Ports
//   i_clk    : single clock, all state changes on the rising edge
//   i_reset  : synchronous active-high reset, aborts any frame in flight
//   i_data   : payload, captured only when i_valid && o_ready at an edge
//   i_valid  : payload offered
//   o_ready  : framer can accept a payload this cycle
//   o_tx     : serial line, idles high
//   o_busy   : frame in progress
//   o_done   : one-cycle pulse in the first idle cycle after the stop bit
module uart_tx_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 3;
`else
  localparam int FRAME_LEN = DATA_WIDTH + 2;
`endif

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(FRAME_LEN + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   frame_q, frame_d;
  logic [BAUD_W-1:0]      baud_q,  baud_d;
  logic [BIT_W-1:0]       bit_q,   bit_d;
  logic                   ready_q, ready_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;
  logic                   accept;

  // The frame register shifts right with ones filling in from the top, so
  // after the stop bit leaves bit 0 the register is back to all ones and the
  // line idles high without any extra muxing on o_tx.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = i_valid && ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef UART_TX_PARITY_EN
          frame_d = {1'b1, ^i_data, i_data, 1'b0};
`else
          frame_d = {1'b1, i_data, 1'b0};
`endif
          baud_d  = '0;
          bit_d   = '0;
          state_d = SHIFT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          frame_d = {1'b1, frame_q[FRAME_LEN-1:1]};
          // The last shift pushes the stop bit out; going idle on that same
          // edge gives an accept-to-idle latency of FRAME_LEN*CLKS_PER_BIT.
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        frame_d = '1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset has priority over any handshake, so an i_valid coinciding with
  // i_reset is dropped and a frame in flight is abandoned without o_done.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      frame_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx    = frame_q[0];
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//   Self-checking bench for uart_tx_framer with DATA_WIDTH=8, CLKS_PER_BIT=4.
//   Directed table of frames, hand-written reset/back-to-back sequences and
//   randomized payloads checked against a bit-list reference model.
module tb_uart_tx_framer;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL  = DW + 3;
`else
  localparam int FL  = DW + 2;
`endif
  localparam int LAT = FL * CPB;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_NOISE  = 1;
  localparam int MODE_HOLD   = 2;

  logic          i_clk;
  logic          i_reset;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_tx;
  logic          o_busy;
  logic          o_done;

  int checksTotal;
  int checksPassed;

  typedef struct {
    logic [7:0]  data;
    int          mode;
    logic [10:0] expFrame;
  } vec_t;

  vec_t vecs[6];

  uart_tx_framer #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_tx   (o_tx),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  // Free-running clock, 10 ns period
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: the line bits of a frame, listed in transmission order
  function automatic logic [10:0] modelFrame(input logic [7:0] d);
    logic bits[$];
    logic [10:0] packed_bits;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    packed_bits = '0;
    for (int i = 0; i < bits.size(); i++) packed_bits[i] = bits[i];
    return packed_bits;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic rst);
    i_valid = valid;
    i_data  = data;
    i_reset = rst;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checksTotal++;
    if (actual == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Accepts one payload, then checks every cycle up to and including the
  // o_done cycle. Inputs for the following edge are driven each cycle
  // according to mode; HOLD leaves i_valid high into the done cycle.
  task automatic runFrame(input logic [7:0] data, input logic [10:0] expFrame,
                          input int mode, input string tag);
    int doneSeen;
    int expTx;
    doneSeen = 0;
    checkOutput($sformatf("%s ready before accept", tag), o_ready, 1);
    applyStimulus(1'b1, data, 1'b0);
    tick();
    for (int k = 0; k <= LAT; k++) begin
      expTx = (k < LAT) ? int'(expFrame[k / CPB]) : 1;
      checkOutput($sformatf("%s tx c%0d", tag, k), o_tx, expTx);
      checkOutput($sformatf("%s done c%0d", tag, k), o_done, (k == LAT) ? 1 : 0);
      checkOutput($sformatf("%s ready c%0d", tag, k), o_ready, (k == LAT) ? 1 : 0);
      checkOutput($sformatf("%s busy c%0d", tag, k), o_busy, (k == LAT) ? 0 : 1);
      if (o_done) doneSeen++;
      case (mode)
        MODE_NOISE: applyStimulus((k < LAT) ? ((k % 2) == 0) : 1'b0, 8'hAA, 1'b0);
        MODE_HOLD:  applyStimulus(1'b1, 8'hFF, 1'b0);
        default:    applyStimulus(1'b0, data, 1'b0);
      endcase
      if (k < LAT) tick();
    end
    checkOutput($sformatf("%s done pulses", tag), doneSeen, 1);
  endtask

  initial begin
    int doneCount;
    int lowCount;
    int gap;
    int mode;
    logic [7:0] rdata;

    checksTotal  = 0;
    checksPassed = 0;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, MODE_NORMAL, 11'h54A};
    vecs[1] = '{8'h07, MODE_NORMAL, 11'h60E};
    vecs[2] = '{8'h81, MODE_NORMAL, 11'h502};
    vecs[3] = '{8'h55, MODE_NOISE,  11'h4AA};
    vecs[4] = '{8'hFF, MODE_NORMAL, 11'h5FE};
    vecs[5] = '{8'h3C, MODE_NOISE,  11'h478};
`else
    vecs[0] = '{8'hA5, MODE_NORMAL, 11'h34A};
    vecs[1] = '{8'h07, MODE_NORMAL, 11'h20E};
    vecs[2] = '{8'h81, MODE_NORMAL, 11'h302};
    vecs[3] = '{8'h55, MODE_NOISE,  11'h2AA};
    vecs[4] = '{8'hFF, MODE_NORMAL, 11'h3FE};
    vecs[5] = '{8'h3C, MODE_NOISE,  11'h278};
`endif

    // Reset with i_valid high: nothing may be accepted
    applyStimulus(1'b1, 8'h5A, 1'b1);
    tick();
    tick();
    checkOutput("reset tx", o_tx, 1);
    checkOutput("reset ready", o_ready, 1);
    checkOutput("reset busy", o_busy, 0);
    checkOutput("reset done", o_done, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("post-reset tx", o_tx, 1);
    checkOutput("post-reset busy", o_busy, 0);
    checkOutput("post-reset ready", o_ready, 1);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      runFrame(vecs[v].data, vecs[v].expFrame, vecs[v].mode, $sformatf("vec%0d", v));
    end

    // Back-to-back: i_valid stays high across the 0x00 frame with 0xFF data;
    // the 0xFF start bit must follow the o_done cycle immediately.
    tick();
    runFrame(8'h00, modelFrame(8'h00), MODE_HOLD, "b2b first");
    runFrame(8'hFF, modelFrame(8'hFF), MODE_NORMAL, "b2b second");

    // Reset 13 edges after accepting 0x3C
    tick();
    checkOutput("abort ready before accept", o_ready, 1);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h3C, 1'b0);
    checkOutput("abort start bit", o_tx, 0);
    for (int k = 1; k <= 12; k++) tick();
    checkOutput("abort busy mid-frame", o_busy, 1);
    applyStimulus(1'b0, 8'h3C, 1'b1);
    tick();
    checkOutput("abort tx", o_tx, 1);
    checkOutput("abort busy", o_busy, 0);
    checkOutput("abort ready", o_ready, 1);
    checkOutput("abort done", o_done, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    doneCount = 0;
    lowCount  = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      tick();
      if (o_done) doneCount++;
      if (!o_tx) lowCount++;
    end
    checkOutput("abort no done pulse", doneCount, 0);
    checkOutput("abort line stays idle", lowCount, 0);
    runFrame(8'h81, modelFrame(8'h81), MODE_NORMAL, "after abort");

    // Randomized payloads with random idle gaps, checked against the model
    for (int r = 0; r < 10; r++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        checkOutput($sformatf("rnd%0d gap tx", r), o_tx, 1);
        checkOutput($sformatf("rnd%0d gap done", r), o_done, 0);
      end
      rdata = 8'($urandom_range(0, 255));
      mode  = $urandom_range(0, 1);
      runFrame(rdata, modelFrame(rdata), mode, $sformatf("rnd%0d", r));
    end

    tick();
    checkOutput("final idle tx", o_tx, 1);
    checkOutput("final idle done", o_done, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
